// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Pure definitions: no latency, no flow control.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHECK,
        RUN,
        ERR
    } state_t;

    localparam int         HDR_BYTES      = 2;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         N_W            = HDR_BYTES * 8;
    localparam logic [7:0] CHK_INIT       = 8'h00;

    // The loader takes stream bytes in every state that still expects frame data.
    function automatic logic accepts_bytes(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian words from a byte stream; word_valid fires with the 4th byte.
// Zero latency on the word output; never stalls, every offered byte is taken.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_word_vld,
    output logic [31:0] o_word_dat
);

    localparam int LANE_W  = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W = (BYTES_PER_WORD - 1) * 8;

    logic [LANE_W-1:0]  r_lane;
    // Holds the three earlier bytes of the current word; the newest byte sits on top.
    logic [SHIFT_W-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_byte_vld) begin
            r_lane  <= r_lane + 1'b1;
            r_shift <= {i_byte_dat, r_shift[SHIFT_W-1:8]};
        end
    end

    assign o_word_vld = i_byte_vld && (r_lane == LANE_W'(BYTES_PER_WORD - 1));
    assign o_word_dat = {i_byte_dat, r_shift};

endmodule

// File: rtl/prog_loader.sv
// Loads a checksummed image into instruction memory, holding the CPU in reset until it verifies.
// im_we/done/error are registered one cycle after the causing byte; rx_ready depends on state only.
module prog_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    state_t         r_state;
    logic [N_W-1:0] r_n;
    logic [N_W-1:0] r_widx;
    logic [7:0]     r_xor;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic           r_cpu_reset;
    logic           r_done;
    logic           r_error;

    logic           w_xfer;
    logic           w_data_byte;
    logic           w_word_vld;
    logic [31:0]    w_word;
    logic [N_W-1:0] w_n_full;
    logic           w_last_word;

    assign rx_ready    = accepts_bytes(r_state);
    assign w_xfer      = rx_valid && rx_ready;
    assign w_data_byte = w_xfer && (r_state == DATA);
    assign w_n_full    = {rx_data, r_n[7:0]};
    assign w_last_word = (r_widx == (r_n - N_W'(1)));

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_byte_vld (w_data_byte),
        .i_byte_dat (rx_data),
        .o_word_vld (w_word_vld),
        .o_word_dat (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HDR_LO;
            r_n         <= '0;
            r_widx      <= '0;
            r_xor       <= CHK_INIT;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we <= 1'b0;

            if (w_data_byte) begin
                r_xor <= r_xor ^ rx_data;
            end

            // Address and data are only touched on a write so they hold between strobes.
            if (w_word_vld) begin
                r_we    <= 1'b1;
                r_addr  <= {{(30 - N_W){1'b0}}, r_widx, 2'b00};
                r_wdata <= w_word;
                r_widx  <= r_widx + 1'b1;
            end

            case (r_state)
                HDR_LO: begin
                    if (w_xfer) begin
                        r_n[7:0] <= rx_data;
                        r_state  <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (w_xfer) begin
                        r_n <= w_n_full;
                        if (32'(w_n_full) > 32'(DEPTH_WORDS)) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end else if (w_n_full == '0) begin
                            r_state <= CHECK;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_vld && w_last_word) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_xfer) begin
                        if (rx_data == r_xor) begin
                            r_state     <= RUN;
                            r_cpu_reset <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign im_we     = r_we;
    assign im_addr   = r_addr;
    assign im_wdata  = r_wdata;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;

endmodule
